// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core.
// Resolves RAW hazards by forwarding from MEM/WB, stalls only on a true
// load-use dependency, holds the pipe while the GEMM accelerator is busy
// (with a deadlock timeout) and raises branch/interrupt flushes.
module pipeline_hazard_ctrl #(
    parameter int XLEN              = 32,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int ACC_TIMEOUT       = 1024,
    parameter int TO_W              = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] inst_exec,
    input  logic [XLEN-1:0] inst_mem,
    input  logic [XLEN-1:0] inst_wb,
    input  logic            reg_wr_mem,
    input  logic            mem_read_mem,
    input  logic            reg_wr_wb,
    input  logic            sel_for_branch,
    input  logic            interupt_sel,
    input  logic            m_busy,
    input  logic            m_done,
    input  logic            acc_timeout_clr,
    output logic [1:0]      forward_sel_1,
    output logic [1:0]      forward_sel_2,
    output logic            flush_sel,
    output logic            stall,
    output logic            acc_timeout
);

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        LOAD_STALL = 2'd1,
        ACC_WAIT   = 2'd2
    } state_t;

    // The entry cycle in NORMAL already stalls, so the counter reloads one short.
    localparam logic [3:0]      LOAD_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [TO_W:0]   TO_LIMIT    = (TO_W+1)'(ACC_TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX      = {TO_W{1'b1}};
    localparam bit              TO_EN       = (ACC_TIMEOUT != 0);

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_acc_timeout;

    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd_mem;
    logic [4:0]      w_rd_wb;
    logic            w_mem_fwd_ok;
    logic            w_wb_fwd_ok;
    logic            w_load_use;
    logic            w_flush;
    logic            w_acc_req;
    logic [TO_W:0]   w_to_next;
    logic            w_to_hit;
    logic            w_stall;
    logic [1:0]      w_fs1;
    logic [1:0]      w_fs2;
    logic            w_unused;

    // MEM wins over WB because it holds the younger value of the register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       mem_ok,
                                           input logic [4:0] rd_mem,
                                           input logic       wb_ok,
                                           input logic [4:0] rd_wb);
        if (mem_ok && (rs == rd_mem)) begin
            return 2'b01;
        end else if (wb_ok && (rs == rd_wb)) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction

    // Counters hold at their limits instead of wrapping.
    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (v == TO_MAX) ? v : v + TO_W'(1);
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

    assign w_rs1    = inst_exec[19:15];
    assign w_rs2    = inst_exec[24:20];
    assign w_rd_mem = inst_mem[11:7];
    assign w_rd_wb  = inst_wb[11:7];

    // Only the register fields matter here; the rest of each word is ignored.
    assign w_unused = ^{inst_exec[XLEN-1:25], inst_exec[14:0],
                        inst_mem[XLEN-1:12],  inst_mem[6:0],
                        inst_wb[XLEN-1:12],   inst_wb[6:0]};

    // A load result is not ready in MEM, so loads never forward from there.
    assign w_mem_fwd_ok = reg_wr_mem & ~mem_read_mem & (w_rd_mem != 5'd0);
    assign w_wb_fwd_ok  = reg_wr_wb & (w_rd_wb != 5'd0);
    assign w_load_use   = mem_read_mem & reg_wr_mem & (w_rd_mem != 5'd0) &
                          ((w_rs1 == w_rd_mem) | (w_rs2 == w_rd_mem));
    assign w_flush      = sel_for_branch | interupt_sel;
    assign w_acc_req    = m_busy & ~m_done;

    assign w_fs1 = fwd_sel(w_rs1, w_mem_fwd_ok, w_rd_mem, w_wb_fwd_ok, w_rd_wb);
    assign w_fs2 = fwd_sel(w_rs2, w_mem_fwd_ok, w_rd_mem, w_wb_fwd_ok, w_rd_wb);

    // Timeout fires in the wait cycle where the count would reach ACC_TIMEOUT.
    assign w_to_next = {1'b0, r_to_cnt} + (TO_W+1)'(1);
    assign w_to_hit  = TO_EN && (r_state == ACC_WAIT) && w_acc_req &&
                       (w_to_next >= TO_LIMIT);

    // Stall decode from the current state and this cycle's hazard inputs.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            NORMAL:     w_stall = w_acc_req | (w_load_use & ~w_flush);
            LOAD_STALL: w_stall = (r_cnt != 4'd0) & ~w_flush;
            ACC_WAIT:   w_stall = w_acc_req & ~w_to_hit;
            default:    w_stall = 1'b0;
        endcase
    end

    // State, stall counters and the sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= NORMAL;
            r_cnt         <= 4'd0;
            r_to_cnt      <= '0;
            r_acc_timeout <= 1'b0;
        end else begin
            if (w_to_hit) begin
                r_acc_timeout <= 1'b1;
            end else if (acc_timeout_clr) begin
                r_acc_timeout <= 1'b0;
            end

            case (r_state)
                NORMAL: begin
                    if (w_acc_req) begin
                        r_state  <= ACC_WAIT;
                        r_to_cnt <= TO_W'(1);
                    end else if (w_load_use && !w_flush) begin
                        r_state <= LOAD_STALL;
                        r_cnt   <= LOAD_RELOAD;
                    end
                end
                LOAD_STALL: begin
                    if (w_flush) begin
                        r_state <= NORMAL;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        // Release cycle: the frozen instruction moves on without re-detection.
                        r_state <= NORMAL;
                    end else begin
                        r_cnt <= sat_dec(r_cnt);
                    end
                end
                ACC_WAIT: begin
                    if (!w_acc_req || w_to_hit) begin
                        r_state  <= NORMAL;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= sat_inc(r_to_cnt);
                    end
                end
                default: begin
                    r_state <= NORMAL;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Every output, combinational ones included, is held at 0 during reset.
    assign forward_sel_1 = reset ? w_fs1 : 2'b00;
    assign forward_sel_2 = reset ? w_fs2 : 2'b00;
    assign flush_sel     = reset ? w_flush : 1'b0;
    assign stall         = reset ? w_stall : 1'b0;
    assign acc_timeout   = reset ? (r_acc_timeout | w_to_hit) : 1'b0;

endmodule
